// File: rtl/qrd_array_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qrd_pkg
// Description : Shared types and default constants for the QR-RLS array
//               front-end sequencer (state encoding, array defaults and the
//               reset value of the forgetting-factor register).
// Revision    : 1.0 - initial release
// ============================================================================
package qrd_pkg;

    // Array defaults
    localparam int unsigned c_def_n      = 4;
    localparam int unsigned c_def_data_w = 32;
    localparam int unsigned c_def_lat    = 8;
    localparam int unsigned c_def_cnt_w  = 16;

    // Reset value of the forgetting factor (opaque bit pattern)
    localparam logic [31:0] c_beta_rst   = 32'h3F7F_BE77;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

endpackage : qrd_pkg
`default_nettype wire

// File: rtl/qrd_array_sequencer_skew_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_line
// Description : DEPTH-stage valid+data shift chain feeding one array column.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               in_valid/data  - element entering the chain
//               out_valid/data - element leaving the chain DEPTH cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module skew_line #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]             r_valid;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
                r_data  <= '0;
            end else begin
                r_valid <= in_valid;
                r_data  <= in_data;
            end
        end
    end else begin : g_multi
        // Stage 0 takes the new element; stage DEPTH-1 drives the column.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
                r_data  <= '0;
            end else begin
                r_valid <= {r_valid[DEPTH-2:0], in_valid};
                r_data  <= {r_data[DEPTH-2:0], in_data};
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

endmodule : skew_line
`default_nettype wire

// File: rtl/qrd_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qrd_array_sequencer
// Description : Front-end controller of the QR-RLS systolic triangular array.
//               Accepts sample vectors on valid/ready, skews element j by j
//               cycles into column j, drives per-column freeze on bubbles,
//               holds the forgetting factor and pulses done once the last
//               vector of a block has drained out of the array.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               in_valid/ready/data/last - input vector handshake
//               cfg_we, cfg_beta, cfg_err - forgetting-factor write / error
//               beta_out                 - current forgetting factor
//               col_valid, col_data      - skewed top-row feed
//               freeze                   - per-column PE hold
//               busy, done, sample_cnt   - block status
// Revision    : 1.0 - initial release
// ============================================================================
module qrd_array_sequencer
    import qrd_pkg::*;
#(
    parameter int unsigned       N        = c_def_n,
    parameter int unsigned       DATA_W   = c_def_data_w,
    parameter int unsigned       LAT      = c_def_lat,
    parameter int unsigned       CNT_W    = c_def_cnt_w,
    parameter logic [DATA_W-1:0] BETA_RST = c_beta_rst
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_last,
    input  logic                cfg_we,
    input  logic [DATA_W-1:0]   cfg_beta,
    output logic                cfg_err,
    output logic [DATA_W-1:0]   beta_out,
    output logic [N-1:0]        col_valid,
    output logic [N*DATA_W-1:0] col_data,
    output logic [N-1:0]        freeze,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sample_cnt
);

    // The drain counter spans the skew of the last column plus array latency.
    localparam int unsigned             c_drain_w    = $clog2(N + LAT);
    localparam logic [c_drain_w-1:0]    c_drain_load = c_drain_w'(N + LAT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_drain_w-1:0]  r_drain_cnt;
    logic [CNT_W-1:0]      r_sample_cnt;
    logic [DATA_W-1:0]     r_beta;
    logic                  r_cfg_err;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_busy;
    logic [N*DATA_W-1:0]   w_inject_data;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = in_last ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (w_accept && in_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // in_ready is masked during reset so nothing is taken in the reset cycle;
    // done is masked too so an abandoned block can never signal completion.
    always_comb begin
        w_in_ready = 1'b0;
        w_done     = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = ~rst;
                w_busy     = 1'b0;
            end
            ST_RUN:   w_in_ready = ~rst;
            ST_DRAIN: w_done     = ~rst && (r_drain_cnt == '0);
            default:  w_busy     = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    // ---------------- drain counter ----------------
    always_ff @(posedge clk) begin
        if (rst)                                       r_drain_cnt <= '0;
        else if (w_accept && in_last)                  r_drain_cnt <= c_drain_load;
        else if (r_state == ST_DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;
    end

    // ---------------- sample counter (saturating) ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE)      r_sample_cnt <= CNT_W'(1);
            else if (r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + 1'b1;
        end
    end

    // ---------------- configuration ----------------
    // Writes are only honoured in IDLE so the array never sees beta change
    // mid-block; a write at any other time is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beta    <= BETA_RST;
            r_cfg_err <= 1'b0;
        end else begin
            if (cfg_we && r_state == ST_IDLE) r_beta <= cfg_beta;
            r_cfg_err <= cfg_we && (r_state != ST_IDLE);
        end
    end

    // ---------------- skew lines ----------------
    // Bubbles carry zero data so the array never sees stale operands.
    assign w_inject_data = w_accept ? in_data : '0;

    for (genvar j = 0; j < N; j++) begin : g_col
        skew_line #(
            .DEPTH  (j + 1),
            .DATA_W (DATA_W)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (w_accept),
            .in_data   (w_inject_data[j*DATA_W +: DATA_W]),
            .out_valid (col_valid[j]),
            .out_data  (col_data[j*DATA_W +: DATA_W])
        );
    end

    assign freeze     = ~col_valid;
    assign in_ready   = w_in_ready;
    assign done       = w_done;
    assign busy       = w_busy;
    assign sample_cnt = r_sample_cnt;
    assign beta_out   = r_beta;
    assign cfg_err    = r_cfg_err;

endmodule : qrd_array_sequencer
`default_nettype wire

// File: tb/tb_qrd_array_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qrd_array_sequencer
// Description : Self-checking bench for qrd_array_sequencer (N=4, LAT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qrd_array_sequencer;

    localparam int N       = 4;
    localparam int DATA_W  = 32;
    localparam int LAT     = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [DATA_W-1:0] BETA_RST = 32'h3F7F_BE77;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N*DATA_W-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic                cfg_we = 1'b0;
    logic [DATA_W-1:0]   cfg_beta = '0;
    logic                cfg_err;
    logic [DATA_W-1:0]   beta_out;
    logic [N-1:0]        col_valid;
    logic [N*DATA_W-1:0] col_data;
    logic [N-1:0]        freeze;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    sample_cnt;

    qrd_array_sequencer #(
        .N(N), .DATA_W(DATA_W), .LAT(LAT), .CNT_W(CNT_W), .BETA_RST(BETA_RST)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .cfg_we(cfg_we),
        .cfg_beta(cfg_beta), .cfg_err(cfg_err), .beta_out(beta_out),
        .col_valid(col_valid), .col_data(col_data), .freeze(freeze),
        .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // cyc is the index of the current cycle; edge cyc closes it.
    int                  cyc = 0;
    bit                  m_run = 0, m_drain = 0, m_err = 0;
    int                  m_done_cyc = 0;
    int                  m_cnt = 0;
    logic [DATA_W-1:0]   m_beta = BETA_RST;
    bit                  hist_v[int];
    logic [N*DATA_W-1:0] hist_d[int];

    function automatic logic [N-1:0] exp_valid();
        logic [N-1:0] r = '0;
        for (int j = 0; j < N; j++) r[j] = hist_v.exists(cyc - 1 - j);
        return r;
    endfunction

    function automatic logic [N*DATA_W-1:0] exp_data();
        logic [N*DATA_W-1:0] r = '0;
        logic [N*DATA_W-1:0] v;
        for (int j = 0; j < N; j++) begin
            if (hist_v.exists(cyc - 1 - j)) begin
                v = hist_d[cyc - 1 - j];
                r[j*DATA_W +: DATA_W] = v[j*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    function automatic bit exp_ready(); return !m_drain && !rst; endfunction
    function automatic bit exp_done();  return !rst && m_drain && (cyc == m_done_cyc); endfunction
    function automatic bit exp_busy();  return m_run || m_drain; endfunction

    function automatic logic [N*DATA_W-1:0] mk(input int base);
        logic [N*DATA_W-1:0] r;
        for (int j = 0; j < N; j++) r[j*DATA_W +: DATA_W] = DATA_W'(base + j);
        return r;
    endfunction

    task automatic drive(input bit v, input logic [N*DATA_W-1:0] d, input bit l,
                         input bit we, input logic [DATA_W-1:0] b);
        in_valid = v; in_data = d; in_last = l; cfg_we = we; cfg_beta = b;
    endtask

    task automatic idle_in();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic advance();
        bit idle, acc;
        @(posedge clk);
        idle = !m_run && !m_drain;
        acc  = in_valid && !m_drain && !rst;
        if (rst) begin
            m_run = 0; m_drain = 0; m_err = 0; m_cnt = 0; m_beta = BETA_RST;
            hist_v.delete(); hist_d.delete();
        end else begin
            m_err = cfg_we && !idle;
            if (cfg_we && idle) m_beta = cfg_beta;
            if (m_drain && cyc == m_done_cyc) m_drain = 0;
            if (acc) begin
                m_cnt = idle ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
                hist_v[cyc] = 1'b1;
                hist_d[cyc] = in_data;
                if (in_last) begin
                    m_run = 0; m_drain = 1; m_done_cyc = cyc + N + LAT;
                end else begin
                    m_run = 1;
                end
            end
        end
        if (hist_v.exists(cyc - N - 1)) begin
            hist_v.delete(cyc - N - 1);
            hist_d.delete(cyc - N - 1);
        end
        cyc++;
        #1;
    endtask

    // Bounded wait for the DUT to return to IDLE.
    task automatic wait_idle();
        int n = 0;
        idle_in();
        @(negedge clk);
        while (busy !== 1'b0 && n < 40) begin
            advance();
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        advance();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        advance();
        advance();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", in_ready); end
        checks++; if (col_valid !== 4'b0000) begin failures++; $display("FAIL reset_col_valid: got %b required 0000", col_valid); end
        checks++; if (col_data !== '0) begin failures++; $display("FAIL reset_col_data: got %h required 0", col_data); end
        checks++; if (freeze !== 4'b1111) begin failures++; $display("FAIL reset_freeze: got %b required 1111", freeze); end
        checks++; if (sample_cnt !== '0) begin failures++; $display("FAIL reset_cnt: got %0d required 0", sample_cnt); end
        checks++; if (beta_out !== BETA_RST) begin failures++; $display("FAIL reset_beta: got %h required %h", beta_out, BETA_RST); end
        checks++; if ({busy, done, cfg_err} !== 3'b000) begin failures++; $display("FAIL reset_flags: busy/done/err got %b required 000", {busy, done, cfg_err}); end
        rst = 1'b0;
        advance();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b required 1", in_ready); end
        checks++; if (freeze !== 4'b1111 || col_valid !== 4'b0000) begin failures++; $display("FAIL post_reset_cols: freeze=%b valid=%b required 1111/0000", freeze, col_valid); end
        advance();
    endtask

    task automatic test_three_vectors();
        for (int r = 0; r <= 16; r++) begin
            if (r < 3) drive(1'b1, mk(4 * r + 1), r == 2, 1'b0, '0);
            else       idle_in();
            @(negedge clk);
            if (r == 1) begin
                checks++; if (col_valid[0] !== 1'b1 || col_data[31:0] !== 32'd1) begin failures++; $display("FAIL three_col0_c1: valid=%b data=%0d required 1/1", col_valid[0], col_data[31:0]); end
            end
            if (r == 4) begin
                checks++; if (col_valid[3] !== 1'b1 || col_data[127:96] !== 32'd4) begin failures++; $display("FAIL three_col3_c4: valid=%b data=%0d required 1/4", col_valid[3], col_data[127:96]); end
            end
            if (r == 6) begin
                checks++; if (col_valid[3] !== 1'b1 || col_data[127:96] !== 32'd12) begin failures++; $display("FAIL three_col3_c6: valid=%b data=%0d required 1/12", col_valid[3], col_data[127:96]); end
            end
            if (r == 3) begin
                checks++; if (sample_cnt !== 16'd3) begin failures++; $display("FAIL three_cnt: got %0d required 3", sample_cnt); end
            end
            if (r >= 3 && r <= 14) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL three_ready_c%0d: got %b required 0", r, in_ready); end
            end
            checks++; if (done !== (r == 14)) begin failures++; $display("FAIL three_done_c%0d: got %b required %b", r, done, r == 14); end
            if (r == 15) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL three_busy_c15: got %b required 0", busy); end
            end
            advance();
        end
    endtask

    task automatic test_gap();
        logic [2:0] v2, f2;
        for (int r = 0; r <= 15; r++) begin
            if (r == 0)      drive(1'b1, mk(100), 1'b0, 1'b0, '0);
            else if (r == 2) drive(1'b1, mk(200), 1'b1, 1'b0, '0);
            else             idle_in();
            @(negedge clk);
            if (r >= 3 && r <= 5) begin
                v2[r-3] = col_valid[2];
                f2[r-3] = freeze[2];
            end
            checks++; if (done !== (r == 14)) begin failures++; $display("FAIL gap_done_c%0d: got %b required %b", r, done, r == 14); end
            advance();
        end
        checks++; if (v2 !== 3'b101) begin failures++; $display("FAIL gap_valid2: cycles 5..3 got %b required 101", v2); end
        checks++; if (f2 !== 3'b010) begin failures++; $display("FAIL gap_freeze2: cycles 5..3 got %b required 010", f2); end
    endtask

    task automatic test_cfg();
        drive(1'b0, '0, 1'b0, 1'b1, 32'h3F80_0000);
        @(negedge clk); advance();
        drive(1'b1, mk(7), 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++; if (beta_out !== 32'h3F80_0000) begin failures++; $display("FAIL cfg_idle_beta: got %h required 3f800000", beta_out); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_idle_err: got %b required 0", cfg_err); end
        advance();
        drive(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk); advance();
        drive(1'b1, mk(9), 1'b1, 1'b0, '0);
        @(negedge clk);
        checks++; if (beta_out !== 32'h3F80_0000) begin failures++; $display("FAIL cfg_run_beta: got %h required 3f800000", beta_out); end
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_run_err: got %b required 1", cfg_err); end
        advance();
        idle_in();
        @(negedge clk);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse: got %b required 0", cfg_err); end
        wait_idle();
    endtask

    task automatic test_reset_in_drain();
        bit seen = 0;
        drive(1'b1, mk(50), 1'b1, 1'b0, '0);
        @(negedge clk); advance();
        idle_in();
        for (int r = 0; r < 3; r++) begin @(negedge clk); advance(); end
        rst = 1'b1;
        @(negedge clk); advance();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstdrain_state: busy=%b ready=%b required 0/1", busy, in_ready); end
        checks++; if (col_valid !== 4'b0000 || sample_cnt !== '0) begin failures++; $display("FAIL rstdrain_clear: valid=%b cnt=%0d required 0/0", col_valid, sample_cnt); end
        for (int r = 0; r < N + LAT + 4; r++) begin
            if (done === 1'b1) seen = 1;
            advance();
            @(negedge clk);
        end
        checks++; if (seen) begin failures++; $display("FAIL rstdrain_done: done seen=1 required 0"); end
        advance();
    endtask

    task automatic test_random();
        logic [N*DATA_W-1:0] d;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int j = 0; j < N; j++) d[j*DATA_W +: DATA_W] = $urandom;
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom);
            @(negedge clk);
            checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready@%0d: got %b required %b", cyc, in_ready, exp_ready()); end
            checks++; if (col_valid !== exp_valid()) begin failures++; $display("FAIL rnd_valid@%0d: got %b required %b", cyc, col_valid, exp_valid()); end
            checks++; if (col_data !== exp_data()) begin failures++; $display("FAIL rnd_data@%0d: got %h required %h", cyc, col_data, exp_data()); end
            checks++; if (freeze !== ~exp_valid()) begin failures++; $display("FAIL rnd_freeze@%0d: got %b required %b", cyc, freeze, ~exp_valid()); end
            checks++; if (done !== exp_done()) begin failures++; $display("FAIL rnd_done@%0d: got %b required %b", cyc, done, exp_done()); end
            checks++; if (busy !== exp_busy()) begin failures++; $display("FAIL rnd_busy@%0d: got %b required %b", cyc, busy, exp_busy()); end
            checks++; if (sample_cnt !== CNT_W'(m_cnt)) begin failures++; $display("FAIL rnd_cnt@%0d: got %0d required %0d", cyc, sample_cnt, m_cnt); end
            checks++; if (beta_out !== m_beta) begin failures++; $display("FAIL rnd_beta@%0d: got %h required %h", cyc, beta_out, m_beta); end
            checks++; if (cfg_err !== m_err) begin failures++; $display("FAIL rnd_err@%0d: got %b required %b", cyc, cfg_err, m_err); end
            advance();
        end
        rst = 1'b1; idle_in();
        @(negedge clk); advance();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        int n = 0;
        bit got = 0;
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, mk(i), i == 69999, 1'b0, '0);
            @(negedge clk);
            if (i == 65535) begin
                checks++; if (sample_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt_reach: got %0d required 65535", sample_cnt); end
            end
            advance();
        end
        idle_in();
        @(negedge clk);
        checks++; if (sample_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt_end: got %0d required 65535", sample_cnt); end
        // cycle after the last accept is n=1; done is due at n=N+LAT
        n = 1;
        while (!got && n <= N + LAT + 5) begin
            if (done === 1'b1) got = 1;
            else begin advance(); @(negedge clk); n++; end
        end
        checks++; if (!got || n != N + LAT) begin failures++; $display("FAIL sat_done_latency: got=%b at %0d required at %0d", got, n, N + LAT); end
        advance();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sat_busy_after: got %b required 0", busy); end
        advance();
    endtask

    initial begin
        test_reset();
        test_three_vectors();
        test_gap();
        test_cfg();
        test_reset_in_drain();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_qrd_array_sequencer
`default_nettype wire
